// File: rtl/sch2pe_pkg.sv
// sch2pe_pkg: shared widths, state encoding and payload sizing for the scheduler-to-PE skid pipe.
package sch2pe_pkg;
    localparam int PE_COL_NUM_D = 32;
    localparam int PE_H_NUM_D   = 4;
    localparam int PE_IC_NUM_D  = 4;
    localparam int IFM_WIDTH_D  = 8;
    localparam int WT_WIDTH_D   = 8;
    localparam int LANE_NUM     = PE_H_NUM_D * PE_IC_NUM_D;
    localparam int DATA_W       = LANE_NUM * PE_COL_NUM_D * IFM_WIDTH_D;
    localparam int WT_DATA_W    = LANE_NUM * WT_WIDTH_D;
    localparam int PAYLOAD_W    = 2 + PE_COL_NUM_D + PE_H_NUM_D + PE_IC_NUM_D + DATA_W + WT_DATA_W;

    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;

    function automatic int pld_w(input int col, input int h, input int ic, input int iw, input int ww);
        return 2 + col + h + ic + h * ic * col * iw + h * ic * ww;
    endfunction
endpackage

// File: rtl/sch2pe_skid_pipe_if.sv
// sch2pe_skid_pipe_if: one PE-array beat with valid/ready handshake.
interface sch2pe_skid_pipe_if #(
    parameter int PE_COL_NUM = 32,
    parameter int PE_H_NUM   = 4,
    parameter int PE_IC_NUM  = 4,
    parameter int IFM_WIDTH  = 8,
    parameter int WT_WIDTH   = 8
);
    logic                                               vld;
    logic                                               rdy;
    logic                                               row_start;
    logic                                               row_done;
    logic [PE_COL_NUM-1:0]                              col_vld;
    logic [PE_H_NUM-1:0]                                row_vld;
    logic [PE_IC_NUM-1:0]                               array_vld;
    logic [PE_H_NUM*PE_IC_NUM*PE_COL_NUM*IFM_WIDTH-1:0] data;
    logic [PE_H_NUM*PE_IC_NUM*WT_WIDTH-1:0]             wt;

    modport master(output vld, row_start, row_done, col_vld, row_vld, array_vld, data, wt, input rdy);
    modport slave(input vld, row_start, row_done, col_vld, row_vld, array_vld, data, wt, output rdy);
endinterface

// File: rtl/sch2pe_pld_reg.sv
// sch2pe_pld_reg: load-enabled payload register with async active-low reset.
module sch2pe_pld_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (ld) q <= d;
endmodule

// File: rtl/sch2pe_skid_pipe.sv
// sch2pe_skid_pipe: scheduler-to-PE beat register with 2-entry skid buffer, flush and stall counter.
module sch2pe_skid_pipe
    import sch2pe_pkg::*;
#(
    parameter int PE_COL_NUM  = PE_COL_NUM_D,
    parameter int PE_H_NUM    = PE_H_NUM_D,
    parameter int PE_IC_NUM   = PE_IC_NUM_D,
    parameter int IFM_WIDTH   = IFM_WIDTH_D,
    parameter int WT_WIDTH    = WT_WIDTH_D,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    sch2pe_skid_pipe_if.slave      s,
    sch2pe_skid_pipe_if.master     m,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int PW = pld_w(PE_COL_NUM, PE_H_NUM, PE_IC_NUM, IFM_WIDTH, WT_WIDTH);
    localparam int SB = 2 + PE_COL_NUM + PE_H_NUM + PE_IC_NUM;

    state_e          state, state_nxt;
    logic            rdy, accept, deliver, main_ld, skid_ld;
    logic [PW-1:0]   s_pld, main_d, main_q, skid_q;

    assign s_pld   = {s.row_start, s.row_done, s.col_vld, s.row_vld, s.array_vld, s.data, s.wt};
    assign accept  = s.vld & rdy;
    assign deliver = m.vld & m.rdy;
    assign s.rdy   = rdy;
    assign m.vld   = state != EMPTY;
    assign main_d  = state == FULL ? skid_q : s_pld;
    // Sideband and masks read as zero once MAIN empties; payload keeps its last value.
    assign {m.row_start, m.row_done, m.col_vld, m.row_vld, m.array_vld} = m.vld ? main_q[PW-1 -: SB] : '0;
    assign {m.data, m.wt} = main_q[PW-SB-1:0];

    always_comb begin
        state_nxt = state;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        if (flush) state_nxt = EMPTY;
        else if (state == EMPTY) begin
            main_ld   = accept;
            state_nxt = accept ? BUSY : EMPTY;
        end else if (state == BUSY) begin
            main_ld   = accept & deliver;
            skid_ld   = accept & !deliver;
            state_nxt = accept ? (deliver ? BUSY : FULL) : (deliver ? EMPTY : BUSY);
        end else begin
            main_ld   = deliver;
            state_nxt = deliver ? BUSY : FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= EMPTY;
            rdy       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rdy       <= state_nxt != FULL;
            stall_cnt <= flush ? '0 : (m.vld & !m.rdy & ~&stall_cnt) ? stall_cnt + STALL_CNT_W'(1) : stall_cnt;
        end

    sch2pe_pld_reg #(.W(PW)) u_main (.clk(clk), .rst_n(rst_n), .ld(main_ld), .d(main_d), .q(main_q));
    sch2pe_pld_reg #(.W(PW)) u_skid (.clk(clk), .rst_n(rst_n), .ld(skid_ld), .d(s_pld), .q(skid_q));
endmodule

// File: tb/tb_sch2pe_skid_pipe.sv
// tb_sch2pe_skid_pipe: directed vectors and corner sequences for the scheduler-to-PE skid pipe.
module tb_sch2pe_skid_pipe;
    import sch2pe_pkg::*;

    typedef struct {
        logic        vld, rdy, fl;
        logic [7:0]  v;
        logic        rs, rd;
        logic [31:0] col;
        logic        e_srdy, e_mvld;
        logic [7:0]  e_v;
        logic        e_rs, e_rd;
        logic [31:0] e_col;
        int          e_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt2;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[16];

    sch2pe_skid_pipe_if s_bus();
    sch2pe_skid_pipe_if m_bus();
    sch2pe_skid_pipe_if s2_bus();
    sch2pe_skid_pipe_if m2_bus();

    sch2pe_skid_pipe dut (.clk(clk), .rst_n(rst_n), .flush(flush), .s(s_bus), .m(m_bus), .stall_cnt(stall_cnt));
    sch2pe_skid_pipe #(.STALL_CNT_W(3)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .s(s2_bus), .m(m2_bus), .stall_cnt(stall_cnt2));

    assign s2_bus.vld       = s_bus.vld;
    assign s2_bus.row_start = s_bus.row_start;
    assign s2_bus.row_done  = s_bus.row_done;
    assign s2_bus.col_vld   = s_bus.col_vld;
    assign s2_bus.row_vld   = s_bus.row_vld;
    assign s2_bus.array_vld = s_bus.array_vld;
    assign s2_bus.data      = s_bus.data;
    assign s2_bus.wt        = s_bus.wt;
    assign m2_bus.rdy       = m_bus.rdy;

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] v);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 8; i++) d[i*8 +: 8] = v + 8'(i);
        return d;
    endfunction

    function automatic logic [WT_DATA_W-1:0] mk_wt(input logic [7:0] v);
        logic [WT_DATA_W-1:0] w;
        for (int i = 0; i < WT_DATA_W / 8; i++) w[i*8 +: 8] = v ^ 8'(i) ^ 8'h80;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_pld(input string nm, input logic [7:0] v);
        logic [DATA_W-1:0] d;
        d = mk_data(v);
        chk({nm, "_data_lo"}, m_bus.data[127:0], d[127:0]);
        chk({nm, "_data_hi"}, m_bus.data[DATA_W-1 -: 128], d[DATA_W-1 -: 128]);
        chk({nm, "_wt"}, m_bus.wt, mk_wt(v));
    endtask

    task automatic drive(input logic vld, input logic rdy, input logic fl, input logic [7:0] v,
                         input logic rs, input logic rd, input logic [31:0] col);
        s_bus.vld       = vld;
        s_bus.row_start = rs;
        s_bus.row_done  = rd;
        s_bus.col_vld   = col;
        s_bus.row_vld   = v[3:0];
        s_bus.array_vld = v[7:4];
        s_bus.data      = mk_data(v);
        s_bus.wt        = mk_wt(v);
        m_bus.rdy       = rdy;
        flush           = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_mvld"}, 128'(m_bus.vld), 128'(0));
        chk({nm, "_side"}, 128'({m_bus.row_start, m_bus.row_done}), 128'(0));
        chk({nm, "_masks"}, 128'({m_bus.col_vld, m_bus.row_vld, m_bus.array_vld}), 128'(0));
        chk({nm, "_data_zero"}, 128'(m_bus.data != '0), 128'(0));
        chk({nm, "_wt"}, 128'(m_bus.wt), 128'(0));
        chk({nm, "_stall"}, 128'(stall_cnt), 128'(0));
        chk({nm, "_stall2"}, 128'(stall_cnt2), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1, 1, 0, 8'(i + 1), i == 0, i == 7, 32'(i + 1),
                        1, 1, 8'(i + 1), i == 0, i == 7, 32'(i + 1), 0};
        vecs[8]  = '{0, 1, 0, 8'h00, 0, 0, 32'h0,        1, 0, 8'h08, 0, 0, 32'h0,        0};
        vecs[9]  = '{1, 0, 0, 8'h11, 1, 0, 32'h11,       1, 1, 8'h11, 1, 0, 32'h11,       0};
        vecs[10] = '{1, 0, 0, 8'h22, 0, 1, 32'h22,       0, 1, 8'h11, 1, 0, 32'h11,       1};
        vecs[11] = '{1, 0, 0, 8'h33, 0, 0, 32'h33,       0, 1, 8'h11, 1, 0, 32'h11,       2};
        vecs[12] = '{0, 1, 0, 8'h00, 0, 0, 32'h0,        1, 1, 8'h22, 0, 1, 32'h22,       2};
        vecs[13] = '{0, 1, 0, 8'h00, 0, 0, 32'h0,        1, 0, 8'h22, 0, 0, 32'h0,        2};
        vecs[14] = '{1, 1, 0, 8'h5A, 0, 1, 32'hFFFFFFFF, 1, 1, 8'h5A, 0, 1, 32'hFFFFFFFF, 2};
        vecs[15] = '{0, 1, 0, 8'h00, 0, 0, 32'h0,        1, 0, 8'h5A, 0, 0, 32'h0,        2};

        drive(0, 0, 0, 8'h00, 0, 0, 32'h0);
        repeat (2) tick();
        chk("rst_srdy", 128'(s_bus.rdy), 128'(0));
        chk_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_srdy", 128'(s_bus.rdy), 128'(1));
        chk("post_rst_mvld", 128'(m_bus.vld), 128'(0));

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vld, vecs[i].rdy, vecs[i].fl, vecs[i].v, vecs[i].rs, vecs[i].rd, vecs[i].col);
            tick();
            chk($sformatf("v%0d_srdy", i), 128'(s_bus.rdy), 128'(vecs[i].e_srdy));
            chk($sformatf("v%0d_mvld", i), 128'(m_bus.vld), 128'(vecs[i].e_mvld));
            chk($sformatf("v%0d_side", i), 128'({m_bus.row_start, m_bus.row_done}), 128'({vecs[i].e_rs, vecs[i].e_rd}));
            chk($sformatf("v%0d_masks", i), 128'({m_bus.col_vld, m_bus.row_vld, m_bus.array_vld}),
                vecs[i].e_mvld ? 128'({vecs[i].e_col, vecs[i].e_v[3:0], vecs[i].e_v[7:4]}) : 128'(0));
            chk($sformatf("v%0d_stall", i), 128'(stall_cnt), 128'(vecs[i].e_stall));
            chk_pld($sformatf("v%0d", i), vecs[i].e_v);
        end

        drive(1, 0, 0, 8'h61, 0, 0, 32'h61);
        tick();
        drive(1, 0, 0, 8'h62, 0, 0, 32'h62);
        tick();
        chk("full_srdy", 128'(s_bus.rdy), 128'(0));
        chk("full_stall", 128'(stall_cnt), 128'(3));
        chk_pld("full", 8'h61);
        drive(1, 0, 1, 8'h63, 0, 0, 32'h63);
        tick();
        chk("flush_mvld", 128'(m_bus.vld), 128'(0));
        chk("flush_srdy", 128'(s_bus.rdy), 128'(1));
        chk("flush_stall", 128'(stall_cnt), 128'(0));
        chk("flush_stall2", 128'(stall_cnt2), 128'(0));
        drive(0, 1, 0, 8'h00, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush_drain%0d_mvld", i), 128'(m_bus.vld), 128'(0));
        end
        drive(1, 1, 1, 8'h64, 0, 0, 32'h64);
        tick();
        chk("flush_empty_mvld", 128'(m_bus.vld), 128'(0));
        drive(0, 1, 0, 8'h00, 0, 0, 32'h0);
        tick();
        chk("flush_empty_drop", 128'(m_bus.vld), 128'(0));

        drive(1, 0, 0, 8'h70, 0, 0, 32'h70);
        tick();
        drive(0, 0, 0, 8'h00, 0, 0, 32'h0);
        repeat (5) tick();
        chk("stall5", 128'(stall_cnt), 128'(5));
        chk("stall5_w3", 128'(stall_cnt2), 128'(5));
        repeat (5) tick();
        chk("stall10", 128'(stall_cnt), 128'(10));
        chk("stall10_sat", 128'(stall_cnt2), 128'(7));
        chk("stall_hold_srdy", 128'(s_bus.rdy), 128'(1));
        chk_pld("stall_hold", 8'h70);
        m_bus.rdy = 1'b1;
        tick();
        chk("stall_done_mvld", 128'(m_bus.vld), 128'(0));
        chk("stall_kept", 128'(stall_cnt), 128'(10));

        drive(1, 0, 0, 8'h80, 1, 1, 32'h80);
        tick();
        chk("pre_rst_mvld", 128'(m_bus.vld), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_srdy", 128'(s_bus.rdy), 128'(0));
        chk_zero("arst");
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rel_srdy_low", 128'(s_bus.rdy), 128'(0));
        tick();
        chk("rel_srdy", 128'(s_bus.rdy), 128'(1));
        chk("rel_no_stale", 128'(m_bus.vld), 128'(0));
        drive(1, 0, 0, 8'h90, 0, 1, 32'h90);
        tick();
        chk("d_mvld", 128'(m_bus.vld), 128'(1));
        chk("d_side", 128'({m_bus.row_start, m_bus.row_done}), 128'({1'b0, 1'b1}));
        chk_pld("d", 8'h90);
        drive(0, 1, 0, 8'h00, 0, 0, 32'h0);
        tick();
        chk("d_done_mvld", 128'(m_bus.vld), 128'(0));
        chk_pld("d_done", 8'h90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
